fifo_video_reader: RTL



---
 rtl/vid_timing_pkg.sv | 34 +++
 rtl/fifo_video_reader_if.sv | 38 +++
 rtl/vid_timing_gen.sv | 54 +++++
 rtl/fifo_video_reader.sv | 130 +++++++++++++
 4 files changed

// File: rtl/vid_timing_pkg.sv
// Shared raster-timing types and constants for the FIFO video reader:
// per-axis timing struct, reader state enum and 720p defaults.
package vid_timing_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FILL = 2'd1,
        RUN       = 2'd2,
        STOPPING  = 2'd3
    } vid_state_t;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } timing_t;

    localparam timing_t H_720P = '{active: 16'd1280, fp: 16'd110, sync: 16'd40, bp: 16'd220};
    localparam timing_t V_720P = '{active: 16'd720,  fp: 16'd5,   sync: 16'd5,  bp: 16'd20};

    function automatic int unsigned sync_start(timing_t t);
        return {16'd0, t.active} + {16'd0, t.fp};
    endfunction

    function automatic int unsigned sync_end(timing_t t);
        return sync_start(t) + {16'd0, t.sync};
    endfunction

    function automatic int unsigned timing_total(timing_t t);
        return sync_end(t) + {16'd0, t.bp};
    endfunction

endpackage

// File: rtl/fifo_video_reader_if.sv
// FIFO-read and video-output signal bundle of fifo_video_reader.
// FIFO_VIDEO_READER_UFCNT_EN adds the underflow_cnt signal.
interface fifo_video_reader_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int RD_DEPTH_WIDTH = 12
);
    logic                    vid_en;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_empty;
    logic [RD_DEPTH_WIDTH:0] rd_water_level;
    logic                    rd_en;
    logic                    frame_start;
    logic                    vid_hs;
    logic                    vid_vs;
    logic                    vid_de;
    logic [DATA_WIDTH-1:0]   vid_data;
    logic                    underflow;
`ifdef FIFO_VIDEO_READER_UFCNT_EN
    logic [15:0]             underflow_cnt;
`endif

    modport master (
        input  vid_en, rd_data, rd_empty, rd_water_level,
        output rd_en, frame_start, vid_hs, vid_vs, vid_de, vid_data, underflow
`ifdef FIFO_VIDEO_READER_UFCNT_EN
        , output underflow_cnt
`endif
    );

    modport slave (
        output vid_en, rd_data, rd_empty, rd_water_level,
        input  rd_en, frame_start, vid_hs, vid_vs, vid_de, vid_data, underflow
`ifdef FIFO_VIDEO_READER_UFCNT_EN
        , input underflow_cnt
`endif
    );

endinterface

// File: rtl/vid_timing_gen.sv
// Raster h/v counters with active/sync decode and frame-origin pulse.
// Counters advance only while run is high and are held at the origin otherwise.
module vid_timing_gen
    import vid_timing_pkg::*;
#(
    parameter timing_t H_T = H_720P,
    parameter timing_t V_T = V_720P
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic pre_de,
    output logic hs,
    output logic vs,
    output logic frame_start,
    output logic frame_last
);
    localparam int unsigned H_TOTAL = timing_total(H_T);
    localparam int unsigned V_TOTAL = timing_total(V_T);
    localparam int H_W = $clog2(H_TOTAL);
    localparam int V_W = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
    localparam logic [H_W:0]   H_ACT  = (H_W + 1)'(H_T.active);
    localparam logic [V_W:0]   V_ACT  = (V_W + 1)'(V_T.active);
    localparam logic [H_W:0]   H_SB   = (H_W + 1)'(sync_start(H_T));
    localparam logic [H_W:0]   H_SE   = (H_W + 1)'(sync_end(H_T));
    localparam logic [V_W:0]   V_SB   = (V_W + 1)'(sync_start(V_T));
    localparam logic [V_W:0]   V_SE   = (V_W + 1)'(sync_end(V_T));

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
        end else begin
            h_cnt <= h_cnt + H_W'(1);
        end
    end

    // Compares use one extra bit so a zero-width back porch cannot overflow.
    assign pre_de      = ({1'b0, h_cnt} < H_ACT) && ({1'b0, v_cnt} < V_ACT);
    assign hs          = ({1'b0, h_cnt} >= H_SB) && ({1'b0, h_cnt} < H_SE);
    assign vs          = ({1'b0, v_cnt} >= V_SB) && ({1'b0, v_cnt} < V_SE);
    assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);
    assign frame_last  = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/fifo_video_reader.sv
// Read-side consumer of the pixel line FIFO: raster timing, fill-level start gate,
// pixel pop and 2-stage output alignment. FIFO_VIDEO_READER_UFCNT_EN adds underflow_cnt.
module fifo_video_reader
    import vid_timing_pkg::*;
#(
    parameter int H_ACTIVE       = 1280,
    parameter int H_FP           = 110,
    parameter int H_SYNC         = 40,
    parameter int H_BP           = 220,
    parameter int V_ACTIVE       = 720,
    parameter int V_FP           = 5,
    parameter int V_SYNC         = 5,
    parameter int V_BP           = 20,
    parameter int HS_POL         = 1,
    parameter int VS_POL         = 1,
    parameter int DATA_WIDTH     = 16,
    parameter int RD_DEPTH_WIDTH = 12,
    parameter int START_LEVEL    = 1024
) (
    input logic                 rd_clk,
    input logic                 rd_rst,
    fifo_video_reader_if.master vid
);
    localparam timing_t H_T = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
    localparam timing_t V_T = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};
    localparam logic [RD_DEPTH_WIDTH:0] START_LVL = (RD_DEPTH_WIDTH + 1)'(START_LEVEL);
    localparam logic [DATA_WIDTH-1:0]   BLACK     = '0;
    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

    vid_state_t state, state_next;
    logic pre_de, hs_raw, vs_raw, frame_start, frame_last;
    logic run_p0, vld_p0, hs_p0, vs_p0, pop_p0, miss_p0;
    logic vld_p1, hs_p1, vs_p1, pop_p1;

    vid_timing_gen #(
        .H_T(H_T),
        .V_T(V_T)
    ) u_timing (
        .clk        (rd_clk),
        .rst        (rd_rst),
        .run        (run_p0),
        .pre_de     (pre_de),
        .hs         (hs_raw),
        .vs         (vs_raw),
        .frame_start(frame_start),
        .frame_last (frame_last)
    );

    always_ff @(posedge rd_clk) begin
        if (rd_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (vid.vid_en) state_next = WAIT_FILL;
            WAIT_FILL: begin
                if (!vid.vid_en)                          state_next = IDLE;
                else if (vid.rd_water_level >= START_LVL) state_next = RUN;
            end
            RUN:       if (!vid.vid_en) state_next = STOPPING;
            // Re-enabling while stopping resumes without breaking the frame.
            STOPPING: begin
                if (vid.vid_en)      state_next = RUN;
                else if (frame_last) state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

    // Stage p0: counters, pop decision
    assign run_p0  = (state == RUN) || (state == STOPPING);
    assign vld_p0  = pre_de && run_p0;
    assign hs_p0   = hs_raw && run_p0;
    assign vs_p0   = vs_raw && run_p0;
    assign pop_p0  = vld_p0 && !vid.rd_empty;
    assign miss_p0 = vld_p0 && vid.rd_empty;

    assign vid.rd_en       = pop_p0;
    assign vid.frame_start = frame_start;

    // Stage p1: FIFO data in flight, popped flag registered
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
            pop_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            pop_p1 <= pop_p0;
        end
    end

    // Stage p2: registered video outputs; a missed pixel is shown as black
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            vid.vid_de   <= 1'b0;
            vid.vid_hs   <= ~HS_ACT;
            vid.vid_vs   <= ~VS_ACT;
            vid.vid_data <= BLACK;
        end else begin
            vid.vid_de   <= vld_p1;
            vid.vid_hs   <= hs_p1 ? HS_ACT : ~HS_ACT;
            vid.vid_vs   <= vs_p1 ? VS_ACT : ~VS_ACT;
            vid.vid_data <= pop_p1 ? vid.rd_data : BLACK;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst)       vid.underflow <= 1'b0;
        else if (miss_p0) vid.underflow <= 1'b1;
    end

`ifdef FIFO_VIDEO_READER_UFCNT_EN
    logic [15:0] uf_cnt;

    always_ff @(posedge rd_clk) begin
        if (rd_rst)                        uf_cnt <= '0;
        else if (miss_p0 && uf_cnt != '1) uf_cnt <= uf_cnt + 16'd1;
    end

    assign vid.underflow_cnt = uf_cnt;
`endif

endmodule
